// File: rtl/dbg_bus_arbiter_if.sv
// Bus bundle between the core, the debug module, the arbiter and the system
// bus slave. The "slave" modport is the arbiter's view, "master" the view of
// whatever surrounds it (masters, slave model, halt source).
interface dbg_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic [DATA_W-1:0] m0_rdata_o;
  logic              m0_ack_o;
  logic              m0_err_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic [DATA_W-1:0] m1_rdata_o;
  logic              m1_ack_o;
  logic              m1_err_o;

  logic              halt_req_i;

  logic              s_req_o;
  logic              s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_wdata_o;
  logic [DATA_W-1:0] s_rdata_i;
  logic              s_ack_i;

  logic              hold_core_o;
  logic [1:0]        owner_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_rdata_o, m0_ack_o, m0_err_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_rdata_o, m1_ack_o, m1_err_o,
    input  halt_req_i,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o,
    input  s_rdata_i, s_ack_i,
    output hold_core_o, owner_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_rdata_o, m0_ack_o, m0_err_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_rdata_o, m1_ack_o, m1_err_o,
    output halt_req_i,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
    output s_rdata_i, s_ack_i,
    input  hold_core_o, owner_o
  );
endinterface

// File: rtl/dbg_bus_arbiter.sv
// Two-master arbiter (core = master 0, debug = master 1) in front of a single
// bus slave. Round-robin grant registered in IDLE, halt excludes the core,
// each grant is aborted after TIMEOUT cycles without a slave ack.
module dbg_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dbg_bus_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GNT_CORE = 2'd1;
  localparam logic [1:0] GNT_DBG  = 2'd2;

  // Counter value seen in the last allowed grant cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             last_dbg_q, last_dbg_d;   // 0: core was last owner
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic c_ok, d_ok, sel_dbg, tmo, own_core, own_dbg;

  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;

  // Eligibility, round-robin pick and timeout detection.
  always_comb begin
    c_ok    = bus.m0_req_i & ~bus.halt_req_i;
    d_ok    = bus.m1_req_i;
    // Debug wins when it is the only candidate or the core went last.
    sel_dbg = d_ok & (~c_ok | ~last_dbg_q);
    // Ack in the boundary cycle takes priority over the abort.
    tmo     = ~bus.s_ack_i & (cnt_q == CNT_LAST);
  end

  // Next-state logic: grant from IDLE, return to IDLE on ack or timeout.
  always_comb begin
    state_d    = state_q;
    last_dbg_d = last_dbg_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (c_ok | d_ok) begin
          state_d    = sel_dbg ? GNT_DBG : GNT_CORE;
          last_dbg_d = sel_dbg;
          cnt_d      = '0;
        end
      end
      GNT_CORE, GNT_DBG: begin
        // Master req is deliberately ignored here; a grant only ends on ack/abort.
        if (bus.s_ack_i || tmo) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also cancels an in-flight grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_dbg_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_dbg_q <= last_dbg_d;
      cnt_q      <= cnt_d;
    end
  end

  // Slave-side mux on the registered owner; everything zero in IDLE.
  always_comb begin
    own_core = (state_q == GNT_CORE);
    own_dbg  = (state_q == GNT_DBG);
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    if (own_core) begin
      s_we    = bus.m0_we_i;
      s_addr  = bus.m0_addr_i;
      s_wdata = bus.m0_wdata_i;
    end else if (own_dbg) begin
      s_we    = bus.m1_we_i;
      s_addr  = bus.m1_addr_i;
      s_wdata = bus.m1_wdata_i;
    end
  end

  assign bus.s_req_o   = own_core | own_dbg;
  assign bus.s_we_o    = s_we;
  assign bus.s_addr_o  = s_addr;
  assign bus.s_wdata_o = s_wdata;

  // Completion / abort go only to the current owner; a late ack in IDLE is dropped.
  assign bus.m0_ack_o   = own_core & bus.s_ack_i;
  assign bus.m0_err_o   = own_core & tmo;
  assign bus.m0_rdata_o = (own_core & bus.s_ack_i) ? bus.s_rdata_i : '0;
  assign bus.m1_ack_o   = own_dbg & bus.s_ack_i;
  assign bus.m1_err_o   = own_dbg & tmo;
  assign bus.m1_rdata_o = (own_dbg & bus.s_ack_i) ? bus.s_rdata_i : '0;

  assign bus.owner_o = {own_dbg, own_core};

  // Core is stalled by halt, by a debug grant, or by a debug grant about to
  // be registered. Forced low during reset so every output reads zero.
  assign bus.hold_core_o = rst_n &
                           (bus.halt_req_i | own_dbg |
                            ((state_q == IDLE) & bus.m1_req_i & sel_dbg));

endmodule

// File: doc/dbg_bus_arbiter.md
Name: dbg_bus_arbiter

Overview:
- Shares one memory/peripheral bus slave port between two masters: the core (master 0) and the JTAG debug module (master 1).
- Sits between the core's data-bus port, the debug module's memory port, and the system bus.
- Uses a registered round-robin grant. Halt blocks the core.
- Generates the core hold signal and aborts transactions that stall, using a per-transaction timeout.

Parameters:
ADDR_W, 32, address width of all masters and the slave.
DATA_W, 32, data width of all masters and the slave.
TIMEOUT, 255, grant-state cycles without s_ack_i before abort (>=2).
CNT_W, 8, timeout counter width (must hold TIMEOUT).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
m0_req_i  input  1  core request; level, held until m0_ack_o or m0_err_o.
m0_we_i  input  1  core write enable.
m0_addr_i  input  ADDR_W  core address.
m0_wdata_i  input  DATA_W  core write data.
m0_rdata_o  output  DATA_W  core read data, valid with m0_ack_o.
m0_ack_o  output  1  core completion pulse.
m0_err_o  output  1  core timeout-abort pulse.
m1_req_i  input  1  debug request (dm op_req); same protocol as m0.
m1_we_i  input  1  debug write enable.
m1_addr_i  input  ADDR_W  debug address.
m1_wdata_i  input  DATA_W  debug write data.
m1_rdata_o  output  DATA_W  debug read data, valid with m1_ack_o.
m1_ack_o  output  1  debug completion pulse.
m1_err_o  output  1  debug timeout-abort pulse.
halt_req_i  input  1  debug halt; while high the core is never granted.
s_req_o  output  1  slave request.
s_we_o  output  1  slave write enable.
s_addr_o  output  ADDR_W  slave address.
s_wdata_o  output  DATA_W  slave write data.
s_rdata_i  input  DATA_W  slave read data.
s_ack_i  input  1  slave completion pulse (1 cycle).
hold_core_o  output  1  stall core pipeline.
owner_o  output  2  00 none, 01 core, 10 debug.

Behaviour:
Reset (asynchronous, immediate, also mid-transaction):
- state=IDLE, last_owner=core, counter=0.
- All outputs 0, including rdata buses.

FSM states: IDLE, GNT_CORE, GNT_DBG.
- IDLE: compute eligibility.
  - c_ok = m0_req_i & ~halt_req_i
  - d_ok = m1_req_i
  - Both eligible: grant the master that is not last_owner.
  - Only one eligible: grant it.
  - Grant registered at the clock edge: state <= GNT_x, last_owner <= x, counter <= 0.
- GNT_x:
  - s_req/we/addr/wdata = master x inputs (combinational mux on registered owner).
  - owner_o = x.
- In GNT_x with s_ack_i=1:
  - m{x}_ack_o = 1 and m{x}_rdata_o = s_rdata_i in the same cycle (combinational).
  - Next state IDLE.
- In GNT_x without ack: counter increments. When counter == TIMEOUT-1 and no ack:
  - m{x}_err_o pulses that cycle.
  - s_req_o drops next cycle; next state IDLE.
  - A late s_ack_i after abort is ignored (IDLE forwards nothing).
- Ack and timeout in the same cycle: ack wins, no err.
- Outputs outside ownership:
  - Non-owner ack/err/rdata = 0.
  - In IDLE, s_req_o = 0 and s_addr/wdata/we = 0.

Latency and back-to-back:
- Request seen at edge N → s_req_o high in cycle N+1.
- Minimum transaction time is 2 cycles (grant + ack). One IDLE cycle always separates transactions.
- A req still high in the IDLE cycle after ack/err is a new transaction.

Halt:
- halt_req_i rising during GNT_CORE does not abort. The core transaction completes, then the core is excluded.
- halt_req_i has no effect on GNT_DBG.

hold_core_o = halt_req_i | (state==GNT_DBG) | (state==IDLE & m1_req_i & arbitration selects debug). Combinational.

Master rule:
- addr/we/wdata are stable while req is high.
- Dropping req before ack is illegal; the arbiter ignores it and holds the grant until ack or timeout.

Test Plan:
- Reset: drive rst_n=0 mid-GNT_DBG with s_req_o=1 → all outputs 0 asynchronously, owner_o=00; after release, idle.
- Single core read: m0_req_i=1, addr=0x1000_0004, slave acks 2 cycles later with 0xDEADBEEF → s_req_o high from the cycle after req, m0_ack_o 1 cycle with m0_rdata_o=0xDEADBEEF, owner_o 01→00.
- Contention after reset: m0_req_i and m1_req_i rise together, slave acks each in 1 cycle → debug granted first (last_owner=core), then core; sequence owner 10,00,01,00, and alternation continues while both remain requesting.
- Halt: halt_req_i=1 with m0_req_i=1 held for 20 cycles → core never granted, hold_core_o=1; m1 write 0x0000_0013 to 0x0 is granted and acked; drop halt → core granted on the next IDLE.
- Timeout: TIMEOUT=8, slave never acks a debug request → m1_err_o pulses in the 8th grant cycle, no m1_ack_o, s_req_o low next cycle; a late s_ack_i is ignored.
- Ack on the boundary: slave acks exactly in the cycle counter==TIMEOUT-1 → m1_ack_o=1, m1_err_o=0.
